// File: rtl/rnd_pkg.sv
// rtl/rnd_pkg.sv - shared constants and state encoding for the random-number arbiter
package rnd_pkg;

  localparam int RND_WIDTH   = 14;
  localparam int RND_NUM_REQ = 4;
  localparam int SHIFTS      = 14;
  localparam int CNT_W       = 4;

  localparam logic [RND_WIDTH-1:0] DEFAULT_SEED = 14'h3FFF;
  localparam logic [RND_WIDTH-1:0] ZERO_SUB     = 14'h0001;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DELIVER = 2'd2
  } state_e;

  // Index width that stays legal for a single requester.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rnd_lfsr_core.sv
// rtl/rnd_lfsr_core.sv - Fibonacci LFSR with seed load and all-zero seed substitution
module rnd_lfsr_core
  import rnd_pkg::*;
#(
  parameter int WIDTH = RND_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             step,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] value
);

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;

  // Load wins over step; an all-zero seed would lock the register up.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == '0) ? WIDTH'(ZERO_SUB) : seed;
    end else if (step) begin
      lfsr_d = {lfsr_q[WIDTH-2:0], lfsr_q[13] ^ lfsr_q[4] ^ lfsr_q[2] ^ lfsr_q[0]};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lfsr_q <= WIDTH'(DEFAULT_SEED);
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value = lfsr_q;

endmodule

// File: rtl/rnd_arbiter.sv
// rtl/rnd_arbiter.sv - round-robin arbiter handing out one 14-step LFSR word per grant
module rnd_arbiter
  import rnd_pkg::*;
#(
  parameter int NUM_REQ = RND_NUM_REQ,
  parameter int WIDTH   = RND_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic [WIDTH-1:0]   seed,
  input  logic               seed_load,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               busy
);

  localparam int IDX_W = idx_width(NUM_REQ);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] winner_q, winner_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] ptr_next;
  logic [IDX_W:0]   sum;
  logic             lfsr_step;
  logic             lfsr_load;
  logic [WIDTH-1:0] lfsr_value;

  rnd_lfsr_core #(.WIDTH(WIDTH)) u_core (
    .clock (clock),
    .reset (reset),
    .step  (lfsr_step),
    .load  (lfsr_load),
    .seed  (seed),
    .value (lfsr_value)
  );

  // Scan from the lowest priority offset down so the nearest requester to ptr wins.
  always_comb begin
    sum  = '0;
    pick = ptr_q;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_q} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(NUM_REQ)) begin
        sum = sum - (IDX_W+1)'(NUM_REQ);
      end
      if (req[sum[IDX_W-1:0]]) begin
        pick = sum[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    ptr_next = winner_q + IDX_W'(1);
    if (winner_q == IDX_W'(NUM_REQ - 1)) begin
      ptr_next = '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    winner_d  = winner_q;
    ptr_d     = ptr_q;
    lfsr_step = 1'b0;
    lfsr_load = 1'b0;
    case (state_q)
      IDLE: begin
        if (seed_load) begin
          lfsr_load = 1'b1;
        end else if (|req) begin
          winner_d = pick;
          cnt_d    = '0;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        lfsr_step = 1'b1;
        if (cnt_q == CNT_W'(SHIFTS - 1)) begin
          state_d = DELIVER;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DELIVER: begin
        ptr_d   = ptr_next;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      winner_q <= '0;
      ptr_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      winner_q <= winner_d;
      ptr_q    <= ptr_d;
    end
  end

  // Outputs decode straight from state so a reset clears them without waiting for a clock.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    busy      = (state_q != IDLE);
    if (state_q == DELIVER) begin
      rsp_valid = NUM_REQ'(1) << winner_q;
      rsp_data  = lfsr_value;
    end
  end

endmodule
